// File: rtl/cw_pkg.sv
// rtl/cw_pkg.sv - shared state, display and keycode definitions for the crossword game controller
package cw_pkg;

  typedef enum logic [2:0] {
    MENU  = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    WIN   = 3'd4,
    DONE  = 3'd5,
    LOSE  = 3'd6
  } state_e;

  localparam logic [2:0] DISP_MENU  = 3'd0;
  localparam logic [2:0] DISP_PLAY  = 3'd1;
  localparam logic [2:0] DISP_PAUSE = 3'd2;
  localparam logic [2:0] DISP_WIN   = 3'd3;
  localparam logic [2:0] DISP_DONE  = 3'd4;
  localparam logic [2:0] DISP_LOSE  = 3'd5;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_ESC   = 8'h29;

  // LOAD shows the play screen so the grid appears as soon as it is fetched
  function automatic logic [2:0] disp_of(input state_e st);
    case (st)
      LOAD, PLAY: disp_of = DISP_PLAY;
      PAUSE:      disp_of = DISP_PAUSE;
      WIN:        disp_of = DISP_WIN;
      DONE:       disp_of = DISP_DONE;
      LOSE:       disp_of = DISP_LOSE;
      default:    disp_of = DISP_MENU;
    endcase
  endfunction

endpackage

// File: rtl/cw_sec_timer.sv
// rtl/cw_sec_timer.sv - per-level seconds counter with clock prescaler, saturating at full scale
module cw_sec_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TIME_W        = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  output logic [TIME_W-1:0] seconds
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [PW-1:0]     pre_q;
  logic [TIME_W-1:0] sec_q;
  logic              pre_wrap;
  logic              sec_sat;

  assign pre_wrap = (pre_q == PW'(TICKS_PER_SEC - 1));
  assign sec_sat  = &sec_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      sec_q <= '0;
    end else if (clr) begin
      pre_q <= '0;
      sec_q <= '0;
    end else if (en) begin
      if (pre_wrap) begin
        pre_q <= '0;
        if (!sec_sat) sec_q <= sec_q + TIME_W'(1);
      end else begin
        pre_q <= pre_q + PW'(1);
      end
    end
  end

  assign seconds = sec_q;

endmodule

// File: rtl/cw_game_ctrl.sv
// rtl/cw_game_ctrl.sv - crossword game-flow FSM; CW_TIME_LIMIT_EN adds the per-level timeout/LOSE screen
module cw_game_ctrl
  import cw_pkg::*;
#(
  parameter int         NUM_LEVELS    = 4,
  parameter logic [7:0] KEY_START     = KEY_ENTER,
  parameter logic [7:0] KEY_PAUSE     = KEY_ESC,
  parameter int         TICKS_PER_SEC = 50_000_000,
  parameter int         WIN_HOLD      = 100_000_000,
  parameter int         TIME_W        = 10,
  parameter int         TIME_LIMIT    = 600,
  localparam int        LW            = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        keycode,
  input  logic              win,
  output logic [2:0]        display,
  output logic              game_reset,
  output logic              load_level,
  output logic [LW-1:0]     level,
  output logic [TIME_W-1:0] seconds,
  output logic [3:0]        hex
);

  localparam int HW = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;

  state_e        state_q, state_d;
  logic [7:0]    key_prev_q;
  logic [LW-1:0] level_q, level_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    display_q;
  logic [3:0]    hex_q, hex_d;
  logic          press_start;
  logic          press_pause;
  logic          tmr_clr;
  logic          tmr_en;
  logic          hold_done;
  logic          last_level;

  assign press_start = (keycode == KEY_START) && (key_prev_q != KEY_START);
  assign press_pause = (keycode == KEY_PAUSE) && (key_prev_q != KEY_PAUSE);
  assign tmr_clr     = (state_q == MENU) || (state_q == LOAD);
  assign tmr_en      = (state_q == PLAY);
  assign hold_done   = (hold_q == HW'(WIN_HOLD - 1));
  assign last_level  = (level_q == LW'(NUM_LEVELS - 1));

  cw_sec_timer #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .TIME_W        (TIME_W)
  ) u_sec_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .seconds (seconds)
  );

`ifdef CW_TIME_LIMIT_EN
  logic timeout;
  assign timeout = (seconds == TIME_W'(TIME_LIMIT));
`endif

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    hold_d  = '0;
    case (state_q)
      MENU: if (press_start) state_d = LOAD;
      LOAD: state_d = PLAY;
      PLAY: begin
        if (win) state_d = WIN;
`ifdef CW_TIME_LIMIT_EN
        else if (timeout) state_d = LOSE;
`endif
        else if (press_pause) state_d = PAUSE;
      end
      PAUSE: begin
        if (press_pause)      state_d = PLAY;
        else if (press_start) state_d = MENU;
      end
      WIN: begin
        if (hold_done || press_start) begin
          if (last_level) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
            level_d = level_q + LW'(1);
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      DONE: if (press_start) state_d = MENU;
`ifdef CW_TIME_LIMIT_EN
      LOSE: if (press_start) state_d = MENU;
`endif
      default: state_d = MENU;
    endcase
    // level reads 0 on the very first MENU cycle, not one cycle later
    if (state_d == MENU) level_d = '0;
  end

  always_comb begin
    hex_d = 4'h0;
    case (state_d)
      LOAD, PLAY, PAUSE, WIN: hex_d = 4'(level_d) + 4'd1;
      DONE:                   hex_d = 4'hF;
      default:                hex_d = 4'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= MENU;
      key_prev_q <= 8'h00;
      level_q    <= '0;
      hold_q     <= '0;
      display_q  <= DISP_MENU;
      hex_q      <= 4'h0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= keycode;
      level_q    <= level_d;
      hold_q     <= hold_d;
      display_q  <= disp_of(state_d);
      hex_q      <= hex_d;
    end
  end

  assign game_reset = (state_q == MENU) || (state_q == LOAD);
  assign load_level = (state_q == LOAD);
  assign display    = display_q;
  assign level      = level_q;
  assign hex        = hex_q;

endmodule

// File: tb/tb_cw_game_ctrl.sv
// tb/tb_cw_game_ctrl.sv - directed self-checking bench for cw_game_ctrl
module tb_cw_game_ctrl;

  logic       clk;
  logic       reset_n;
  logic [7:0] keycode;
  logic       win;
  logic [2:0] display;
  logic       game_reset;
  logic       load_level;
  logic [0:0] level;
  logic [2:0] seconds;
  logic [3:0] hex;

  int checks;
  int errors;
  int cnt;

  cw_game_ctrl #(
    .NUM_LEVELS    (2),
    .KEY_START     (8'h28),
    .KEY_PAUSE     (8'h29),
    .TICKS_PER_SEC (4),
    .WIN_HOLD      (8),
    .TIME_W        (3),
    .TIME_LIMIT    (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .keycode    (keycode),
    .win        (win),
    .display    (display),
    .game_reset (game_reset),
    .load_level (load_level),
    .level      (level),
    .seconds    (seconds),
    .hex        (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    keycode = 8'h00;
    win     = 1'b0;
    step(2);
    chk("rst_display", display, 0);
    chk("rst_game_reset", game_reset, 1);
    chk("rst_load_level", load_level, 0);
    chk("rst_hex", hex, 0);
    chk("rst_level", level, 0);
    chk("rst_seconds", seconds, 0);
    reset_n = 1'b1;

    // start: held Enter gives a single LOAD pulse
    keycode = 8'h28;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (load_level) cnt++;
    end
    keycode = 8'h00;
    chk("start_load_pulses", cnt, 1);
    chk("start_display", display, 1);
    chk("start_level", level, 0);
    chk("start_hex", hex, 1);
    chk("start_game_reset", game_reset, 0);
    chk("start_seconds", seconds, 0);

    // pause / resume, TICKS_PER_SEC=4
    step(1);
    chk("play_sec1", seconds, 1);
    step(4);
    chk("play_sec2", seconds, 2);
    keycode = 8'h29;
    step(1);
    keycode = 8'h00;
    chk("pause_display", display, 2);
    step(20);
    chk("pause_display_hold", display, 2);
    chk("pause_sec_frozen", seconds, 2);
    keycode = 8'h29;
    step(1);
    keycode = 8'h00;
    chk("resume_display", display, 1);
    step(3);
    chk("resume_sec3", seconds, 3);

    // level advance via banner timeout
    win = 1'b1;
    step(1);
    win = 1'b0;
    chk("win_display", display, 3);
    chk("win_hex", hex, 1);
    cnt = 1;
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (display == 3'd3) cnt++;
    end
    chk("win_banner_cycles", cnt, 8);
    chk("win_sec_frozen", seconds, 3);
    step(1);
    chk("adv_load_level", load_level, 1);
    chk("adv_game_reset", game_reset, 1);
    chk("adv_level", level, 1);
    chk("adv_hex", hex, 2);
    step(1);
    chk("adv_play_display", display, 1);
    chk("adv_sec_cleared", seconds, 0);

    // win beats Esc in the same cycle; Enter skips banner on last level
    keycode = 8'h29;
    win = 1'b1;
    step(1);
    keycode = 8'h00;
    win = 1'b0;
    chk("simul_win_not_pause", display, 3);
    keycode = 8'h28;
    step(1);
    keycode = 8'h00;
    chk("done_display", display, 4);
    chk("done_hex", hex, 4'hF);
    step(1);
    keycode = 8'h28;
    step(1);
    keycode = 8'h00;
    chk("menu_display", display, 0);
    chk("menu_level", level, 0);
    chk("menu_hex", hex, 0);
    chk("menu_game_reset", game_reset, 1);

    // skip banner in level 0, then async reset mid-WIN in level 1
    step(1);
    keycode = 8'h28;
    step(1);
    keycode = 8'h00;
    chk("t5_load", load_level, 1);
    step(1);
    win = 1'b1;
    step(1);
    win = 1'b0;
    step(2);
    chk("t5_win", display, 3);
    keycode = 8'h28;
    step(1);
    keycode = 8'h00;
    chk("skip_load", load_level, 1);
    chk("skip_level", level, 1);
    step(1);
    win = 1'b1;
    step(1);
    win = 1'b0;
    step(1);
    chk("t5_win_l1", display, 3);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_display", display, 0);
    chk("async_game_reset", game_reset, 1);
    chk("async_level", level, 0);
    chk("async_hex", hex, 0);
    step(1);
    reset_n = 1'b1;

    // idle in PLAY past TIME_LIMIT=3 seconds
    keycode = 8'h28;
    step(1);
    keycode = 8'h00;
    step(1);
    chk("t6_play", display, 1);
    step(13);
`ifdef CW_TIME_LIMIT_EN
    chk("lose_display", display, 5);
    chk("lose_game_reset", game_reset, 0);
    step(8);
    chk("lose_sec_frozen", seconds, 3);
    keycode = 8'h28;
    step(1);
    keycode = 8'h00;
    chk("lose_menu", display, 0);
`else
    chk("nolimit_display", display, 1);
    chk("nolimit_sec", seconds, 3);
    step(40);
    chk("sat_display", display, 1);
    chk("sat_seconds", seconds, 7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
